// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU command sequencer: FSM states, op codes and
// the one-hot selector constants driven onto the ALU.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOT  = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_SUB  = 3'd5;
    localparam logic [2:0] OP_MULT = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    localparam logic [2:0] IN_PERSIST = 3'b100;
    localparam logic [2:0] IN_LOAD    = 3'b010;
    localparam logic [2:0] IN_RESET   = 3'b001;

    localparam logic [6:0] OUT_AND  = 7'b0000001;
    localparam logic [6:0] OUT_OR   = 7'b0000010;
    localparam logic [6:0] OUT_NOT  = 7'b0000100;
    localparam logic [6:0] OUT_XOR  = 7'b0001000;
    localparam logic [6:0] OUT_ADD  = 7'b0010000;
    localparam logic [6:0] OUT_SUB  = 7'b0100000;
    localparam logic [6:0] OUT_MULT = 7'b1000000;

    function automatic logic [6:0] op_to_onehot(input logic [2:0] op);
        logic [6:0] oh;
        oh = '0;
        case (op)
            OP_AND:  oh = OUT_AND;
            OP_OR:   oh = OUT_OR;
            OP_NOT:  oh = OUT_NOT;
            OP_XOR:  oh = OUT_XOR;
            OP_ADD:  oh = OUT_ADD;
            OP_SUB:  oh = OUT_SUB;
            OP_MULT: oh = OUT_MULT;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/seq_cmd_fifo.sv
// Command queue for the ALU sequencer; count-based full/empty, power-of-2 depth.
module seq_cmd_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator for the 8-bit ALU: queues commands, drives operands/selectors,
// waits the ALU latency and returns result + error on a valid/ready channel.
//
//  state | meaning
//  IDLE  | waiting for a queued command (pops when on & FIFO non-empty)
//  ISSUE | operands and selectors presented to the ALU for one cycle
//  WAIT  | ALU latency countdown, result captured at terminal count
//  DONE  | result held on res_* until consumed
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             on,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_use_acc,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_num1,
    output logic [WIDTH-1:0] alu_num2,
    output logic [2:0]       alu_in_sel,
    output logic [6:0]       alu_out_sel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
    output logic [7:0]       err_count,
    output logic             busy
);

    localparam int CW    = 2*WIDTH + 4;
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    logic [CW-1:0]    fifo_wdata, fifo_rdata;
    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic             f_use_acc;
    logic [2:0]       f_op;
    logic [WIDTH-1:0] f_a, f_b;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] num1_q, num1_d, num2_q, num2_d;
    logic [2:0]       in_sel_q, in_sel_d;
    logic [6:0]       out_sel_q, out_sel_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_err_q, res_err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    assign fifo_wdata = {cmd_use_acc, cmd_op, cmd_a, cmd_b};
    assign {f_use_acc, f_op, f_a, f_b} = fifo_rdata;
    // Ready only looks at the registered count, so a same-cycle pop never frees a full slot.
    assign cmd_ready  = on & ~fifo_full & ~rst;
    assign fifo_push  = cmd_valid & cmd_ready;

    seq_cmd_fifo #(
        .W     (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        num1_d     = num1_q;
        num2_d     = num2_q;
        in_sel_d   = IN_PERSIST;
        out_sel_d  = out_sel_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        err_cnt_d  = err_cnt_q;
        fifo_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (on && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    op_d     = f_op;
                    state_d  = ST_ISSUE;
                    // An illegal op leaves the ALU interface untouched.
                    if (f_op != OP_ILL) begin
                        num1_d    = f_a;
                        num2_d    = f_b;
                        out_sel_d = op_to_onehot(f_op);
                        in_sel_d  = f_use_acc ? IN_PERSIST : IN_LOAD;
                    end
                end
            end
            ST_ISSUE: begin
                if (op_q == OP_ILL) begin
                    res_data_d = '0;
                    res_err_d  = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    cnt_d   = CNT_W'(LAT - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    res_data_d = alu_result;
                    res_err_d  = alu_overflow & (op_q == OP_MULT);
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                    if (res_err_q && err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            num1_q     <= '0;
            num2_q     <= '0;
            in_sel_q   <= IN_RESET;
            out_sel_q  <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            num1_q     <= num1_d;
            num2_q     <= num2_d;
            in_sel_q   <= in_sel_d;
            out_sel_q  <= out_sel_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign alu_num1    = num1_q;
    assign alu_num2    = num2_q;
    assign alu_in_sel  = in_sel_q;
    assign alu_out_sel = out_sel_q;
    assign res_valid   = (state_q == ST_DONE);
    assign res_data    = res_data_q;
    assign res_err     = res_err_q;
    assign err_count   = err_cnt_q;
    assign busy        = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a two-stage pipelined ALU model.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst, on, cmd_valid, cmd_ready, cmd_use_acc;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a, cmd_b, alu_num1, alu_num2, alu_result, res_data, err_count;
    logic [2:0] alu_in_sel;
    logic [6:0] alu_out_sel;
    logic       alu_overflow, res_valid, res_ready, res_err, busy;

    int n_pass  = 0;
    int n_total = 0;
    int exp_errs = 0;

    typedef struct {
        logic [2:0] op;
        logic       use_acc;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] data;
        logic       err;
        logic [2:0] in_sel;
        logic [6:0] out_sel;
        int         lat;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       err;
    } res_t;

    vec_t vecs[10];
    res_t exp_q[$];

    alu_cmd_sequencer #(.WIDTH(8), .DEPTH(4), .LAT(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .on           (on),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_use_acc  (cmd_use_acc),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .alu_num1     (alu_num1),
        .alu_num2     (alu_num2),
        .alu_in_sel   (alu_in_sel),
        .alu_out_sel  (alu_out_sel),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_err      (res_err),
        .err_count    (err_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // ALU model: result appears two clocks after operands/selectors are presented.
    function automatic logic [7:0] alu_f(input logic [7:0] x, input logic [7:0] y, input logic [6:0] s);
        logic [7:0] r;
        case (s)
            7'b0000001: r = x & y;
            7'b0000010: r = x | y;
            7'b0000100: r = ~x;
            7'b0001000: r = x ^ y;
            7'b0010000: r = x + y;
            7'b0100000: r = x - y;
            7'b1000000: r = x * y;
            default:    r = 8'hEE;
        endcase
        return r;
    endfunction

    logic [7:0] p0_res, p1_res;
    logic       p0_ovf, p1_ovf;
    always_ff @(posedge clk) begin
        p0_res <= alu_f(alu_num1, alu_num2, alu_out_sel);
        p0_ovf <= (16'(alu_num1) * 16'(alu_num2)) > 16'd255;
        p1_res <= p0_res;
        p1_ovf <= p0_ovf;
    end
    assign alu_result   = p1_res;
    assign alu_overflow = p1_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int  lat;
        cmd_valid   = 1'b1;
        cmd_op      = v.op;
        cmd_use_acc = v.use_acc;
        cmd_a       = v.a;
        cmd_b       = v.b;
        chk("vec_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("vec_issue_in_sel", 32'(alu_in_sel), 32'(v.in_sel));
        chk("vec_issue_out_sel", 32'(alu_out_sel), 32'(v.out_sel));
        if (v.op != 3'd7) begin
            chk("vec_issue_num1", 32'(alu_num1), 32'(v.a));
            chk("vec_issue_num2", 32'(alu_num2), 32'(v.b));
        end
        lat = 1;
        while (!res_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("vec_latency", 32'(lat), 32'(v.lat));
        chk("vec_res_data", 32'(res_data), 32'(v.data));
        chk("vec_res_err", 32'(res_err), 32'(v.err));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        if (v.err) exp_errs++;
        chk("vec_err_count", 32'(err_count), 32'(exp_errs));
        chk("vec_valid_drop", 32'(res_valid), 32'd0);
        chk("vec_busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic drain(input int budget);
        int   cyc;
        res_t r;
        cyc = 0;
        res_ready = 1'b1;
        while (exp_q.size() > 0 && cyc < budget) begin
            if (res_valid) begin
                r = exp_q.pop_front();
                chk("drain_data", 32'(res_data), 32'(r.data));
                chk("drain_err", 32'(res_err), 32'(r.err));
                if (r.err) exp_errs++;
            end
            tick();
            cyc++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   sent, got, first_block, w;
        logic any_valid;
        res_t r;

        //               op    acc   a      b      data   err   in_sel  out_sel      lat
        vecs[0] = '{3'd4, 1'b0, 8'd5,   8'd3,   8'd8,   1'b0, 3'b010, 7'b0010000, 4};
        vecs[1] = '{3'd6, 1'b0, 8'd20,  8'd20,  8'd144, 1'b1, 3'b010, 7'b1000000, 4};
        vecs[2] = '{3'd0, 1'b1, 8'hF0,  8'h3C,  8'h30,  1'b0, 3'b100, 7'b0000001, 4};
        vecs[3] = '{3'd1, 1'b0, 8'hF0,  8'h0F,  8'hFF,  1'b0, 3'b010, 7'b0000010, 4};
        vecs[4] = '{3'd2, 1'b0, 8'h55,  8'h00,  8'hAA,  1'b0, 3'b010, 7'b0000100, 4};
        vecs[5] = '{3'd3, 1'b0, 8'hAA,  8'hFF,  8'h55,  1'b0, 3'b010, 7'b0001000, 4};
        vecs[6] = '{3'd5, 1'b0, 8'd3,   8'd5,   8'hFE,  1'b0, 3'b010, 7'b0100000, 4};
        vecs[7] = '{3'd6, 1'b0, 8'd15,  8'd17,  8'd255, 1'b0, 3'b010, 7'b1000000, 4};
        vecs[8] = '{3'd7, 1'b0, 8'd9,   8'd9,   8'd0,   1'b1, 3'b100, 7'b1000000, 2};
        vecs[9] = '{3'd5, 1'b0, 8'd200, 8'd100, 8'd100, 1'b0, 3'b010, 7'b0100000, 4};

        rst = 1'b1; on = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_use_acc = 1'b0;
        cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
        tick();
        tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_in_sel", 32'(alu_in_sel), 32'b001);
        chk("rst_out_sel", 32'(alu_out_sel), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_in_sel", 32'(alu_in_sel), 32'b100);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Back-to-back burst: five accepted before ready drops, all complete in order.
        sent = 0; got = 0; first_block = -1;
        res_ready = 1'b1;
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_use_acc = 1'b0; cmd_a = 8'd1; cmd_b = 8'd2;
        for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
            logic       acc, rsp, re;
            logic [7:0] rd;
            acc = cmd_valid & cmd_ready;
            rsp = res_valid & res_ready;
            rd  = res_data;
            re  = res_err;
            if (cmd_valid && !cmd_ready && first_block < 0) first_block = sent;
            tick();
            if (acc) begin
                exp_q.push_back('{8'(10*sent + 3), 1'b0});
                sent++;
                if (sent < 6) cmd_a = 8'(10*sent + 1);
                else cmd_valid = 1'b0;
            end
            if (rsp) begin
                if (exp_q.size() == 0) begin
                    chk("burst_extra_result", 32'd1, 32'(exp_q.size()));
                end else begin
                    r = exp_q.pop_front();
                    chk("burst_data", 32'(rd), 32'(r.data));
                    chk("burst_err", 32'(re), 32'(r.err));
                end
                got++;
            end
        end
        res_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("burst_first_block", 32'(first_block), 32'd5);
        chk("burst_sent", 32'(sent), 32'd6);
        chk("burst_got", 32'(got), 32'd6);
        exp_q.delete();

        // Stall in DONE with two commands queued behind, then hold them with on=0.
        cmd_valid = 1'b1; cmd_op = 3'd6; cmd_a = 8'd20; cmd_b = 8'd20;
        tick();
        cmd_op = 3'd4; cmd_a = 8'd7; cmd_b = 8'd9;
        tick();
        cmd_op = 3'd3; cmd_a = 8'h0F; cmd_b = 8'hF0;
        tick();
        cmd_valid = 1'b0;
        on = 1'b0;
        w = 0;
        while (!res_valid && w < 20) begin
            tick();
            w++;
        end
        chk("stall_valid_seen", 32'(res_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", 32'(res_valid), 32'd1);
            chk("stall_data", 32'(res_data), 32'd144);
            chk("stall_err", 32'(res_err), 32'd1);
            chk("stall_in_sel", 32'(alu_in_sel), 32'b100);
            chk("stall_num1", 32'(alu_num1), 32'd20);
            tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        exp_errs++;
        chk("stall_err_count", 32'(err_count), 32'(exp_errs));
        for (int k = 0; k < 4; k++) begin
            chk("off_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("off_no_pop", 32'(res_valid), 32'd0);
            chk("off_busy", 32'(busy), 32'd1);
            chk("off_in_sel", 32'(alu_in_sel), 32'b100);
            tick();
        end
        on = 1'b1;
        exp_q.push_back('{8'd16, 1'b0});
        exp_q.push_back('{8'hFF, 1'b0});
        drain(40);
        chk("on_busy_clear", 32'(busy), 32'd0);

        // Reset during WAIT aborts the in-flight command and flushes the queue.
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_a = 8'd1; cmd_b = 8'd1;
        tick();
        cmd_a = 8'd2; cmd_b = 8'd2;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("wait_in_sel", 32'(alu_in_sel), 32'b100);
        chk("wait_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        chk("abort_res_valid", 32'(res_valid), 32'd0);
        chk("abort_in_sel", 32'(alu_in_sel), 32'b001);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("abort_err_count", 32'(err_count), 32'd0);
        chk("abort_out_sel", 32'(alu_out_sel), 32'd0);
        rst = 1'b0;
        exp_errs = 0;
        res_ready = 1'b1;
        any_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (res_valid) any_valid = 1'b1;
        end
        res_ready = 1'b0;
        chk("abort_no_result", 32'(any_valid), 32'd0);
        chk("abort_busy_after", 32'(busy), 32'd0);
        run_vec(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
